// File: rtl/conv_pkg.sv
// Shared constants and window layout helpers for the 3x3 convolution path.
// Pure declarations, no logic and no latency.
// No handshake here; producers and consumers import these so the layout stays in step.
package conv_pkg;

  // Default datapath shape; blocks override these through their own parameters.
  localparam int DATAW     = 8;
  localparam int IFM_CH    = 8;
  localparam int K         = 3;
  localparam int WIN_ELEMS = IFM_CH * K * K;
  localparam int PIXW      = DATAW * IFM_CH;

  // Flat element index inside a window bus: channel-major, then row (ky), then column (kx).
  // The conv-sum stage uses the same function, so both ends agree on the layout.
  function automatic int win_idx(input int c, input int ky, input int kx);
    return c * K * K + ky * K + kx;
  endfunction

endpackage

// File: rtl/conv3x3_win_gen_if.sv
// Pixel-in / window-out bundle for conv3x3_win_gen.
// Combinational wires only, no latency.
// No backpressure signals: the pixel side is strobe-only and the window side is a pulse.
interface conv3x3_win_gen_if #(
  parameter int DATAW  = conv_pkg::DATAW,
  parameter int IFM_CH = conv_pkg::IFM_CH,
  parameter int K      = conv_pkg::K
);
  import conv_pkg::*;

  logic                          in_vld;
  logic                          in_sof;
  logic [DATAW*IFM_CH-1:0]       in_pix;
  logic                          win_vld;
  logic [DATAW*IFM_CH*K*K-1:0]   win_data;
  logic                          win_last;
  logic                          sof_err;

  // Pixel source side.
  modport master (
    output in_vld, in_sof, in_pix,
    input  win_vld, win_data, win_last, sof_err
  );

  // Window generator side.
  modport slave (
    input  in_vld, in_sof, in_pix,
    output win_vld, win_data, win_last, sof_err
  );

endinterface

// File: rtl/conv_line_buf.sv
// One image row of pixels, indexed by column; async read, sync write, read-before-write.
// Read data is combinational from addr; a write lands on the next clock edge.
// No backpressure; storage is intentionally not reset.
module conv_line_buf #(
  parameter int WIDTH = conv_pkg::PIXW,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  import conv_pkg::*;

  logic [WIDTH-1:0] mem [DEPTH];

  // Reads see the old contents in the same cycle a write to that address is issued.
  assign rdata = mem[addr];

  // Row storage write; contents after reset are don't-care since rows refill before use.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv3x3_win_gen.sv
// Raster pixel stream -> valid-padding 3x3 windows on a flat channel-major bus.
// Latency: win_vld one cycle after the pixel that completes a window.
// No backpressure: every in_vld cycle consumes a pixel. Macro CONV_WIN_STRIDE2_EN selects stride-2 emission.
module conv3x3_win_gen #(
  parameter int DATAW  = conv_pkg::DATAW,
  parameter int IFM_CH = conv_pkg::IFM_CH,
  parameter int K      = conv_pkg::K,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  conv3x3_win_gen_if.slave  bus
);
  import conv_pkg::*;

  localparam int PIX_W = DATAW * IFM_CH;
  localparam int WIN_W = PIX_W * K * K;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);

`ifdef CONV_WIN_STRIDE2_EN
  // Final emitted window sits at the largest even top-left offset that still fits.
  localparam int LAST_ROW = 2 + 2 * ((IMG_H - 3) / 2);
  localparam int LAST_COL = 2 + 2 * ((IMG_W - 3) / 2);
`else
  localparam int LAST_ROW = IMG_H - 1;
  localparam int LAST_COL = IMG_W - 1;
`endif

  generate
    if (K != 3) begin : g_bad_k
      $error("conv3x3_win_gen: only K=3 is supported");
    end
    if (IMG_W < 3 || IMG_H < 3) begin : g_bad_dim
      $error("conv3x3_win_gen: IMG_W and IMG_H must be at least 3");
    end
  endgenerate

  logic [RW-1:0]    row_q;
  logic [CW-1:0]    col_q;
  logic [RW-1:0]    cur_row;
  logic [CW-1:0]    cur_col;
  logic             sof_mid;
  logic             stride_ok;
  logic             emit;
  logic             last_px;
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;
  logic [PIX_W-1:0] new_col [3];
  // Two older window columns, [kx][ky]; the newest column is the incoming one,
  // so it is taken straight from the line buffers and the pixel input.
  logic [PIX_W-1:0] hist_q [2][3];
  logic [WIN_W-1:0] win_nxt;
  logic [WIN_W-1:0] win_data_q;
  logic             win_vld_q;
  logic             win_last_q;
  logic             sof_err_q;

  // Position of the incoming pixel; a start-of-frame re-anchors it at the origin.
  always_comb begin
    cur_row = row_q;
    cur_col = col_q;
    if (bus.in_sof) begin
      cur_row = '0;
      cur_col = '0;
    end
  end

  assign sof_mid = bus.in_vld & bus.in_sof & ((row_q != '0) | (col_q != '0));

`ifdef CONV_WIN_STRIDE2_EN
  // Top-left is (row-2, col-2); both even is the same as row and col both even.
  assign stride_ok = ~cur_row[0] & ~cur_col[0];
`else
  assign stride_ok = 1'b1;
`endif

  // A window is complete once two full rows and two columns of the current row are in.
  assign emit    = bus.in_vld & (cur_row >= RW'(2)) & (cur_col >= CW'(2)) & stride_ok;
  assign last_px = (cur_row == RW'(LAST_ROW)) & (cur_col == CW'(LAST_COL));

  // lb1 holds the previous row, lb0 the row before; each pixel ages a column down one slot.
  conv_line_buf #(
    .WIDTH (PIX_W),
    .DEPTH (IMG_W)
  ) u_lb0 (
    .clk   (clk),
    .we    (bus.in_vld),
    .addr  (cur_col),
    .wdata (lb1_rd),
    .rdata (lb0_rd)
  );

  conv_line_buf #(
    .WIDTH (PIX_W),
    .DEPTH (IMG_W)
  ) u_lb1 (
    .clk   (clk),
    .we    (bus.in_vld),
    .addr  (cur_col),
    .wdata (bus.in_pix),
    .rdata (lb1_rd)
  );

  // Incoming window column, top (oldest row) to bottom (current row).
  always_comb begin
    new_col[0] = lb0_rd;
    new_col[1] = lb1_rd;
    new_col[2] = bus.in_pix;
  end

  // Scatter the three columns into the channel-major flat window bus.
  always_comb begin
    win_nxt = '0;
    for (int c = 0; c < IFM_CH; c++) begin
      for (int ky = 0; ky < 3; ky++) begin
        win_nxt[win_idx(c, ky, 0)*DATAW +: DATAW] = hist_q[0][ky][c*DATAW +: DATAW];
        win_nxt[win_idx(c, ky, 1)*DATAW +: DATAW] = hist_q[1][ky][c*DATAW +: DATAW];
        win_nxt[win_idx(c, ky, 2)*DATAW +: DATAW] = new_col[ky][c*DATAW +: DATAW];
      end
    end
  end

  // Raster position counters; wrap at the frame end so the next pixel starts a new frame.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      row_q <= '0;
      col_q <= '0;
    end else if (bus.in_vld) begin
      if (cur_col == CW'(IMG_W - 1)) begin
        col_q <= '0;
        row_q <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col_q <= cur_col + 1'b1;
        row_q <= cur_row;
      end
    end
  end

  // Window column shift: oldest column drops out, incoming column moves in.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int kx = 0; kx < 2; kx++) begin
        for (int ky = 0; ky < 3; ky++) begin
          hist_q[kx][ky] <= '0;
        end
      end
    end else if (bus.in_vld) begin
      for (int ky = 0; ky < 3; ky++) begin
        hist_q[0][ky] <= hist_q[1][ky];
        hist_q[1][ky] <= new_col[ky];
      end
    end
  end

  // Output register: flags pulse for one cycle, window data holds between emissions.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      win_vld_q  <= 1'b0;
      win_last_q <= 1'b0;
      sof_err_q  <= 1'b0;
      win_data_q <= '0;
    end else begin
      win_vld_q  <= emit;
      win_last_q <= emit & last_px;
      sof_err_q  <= sof_mid;
      if (emit) begin
        win_data_q <= win_nxt;
      end
    end
  end

  assign bus.win_vld  = win_vld_q;
  assign bus.win_last = win_last_q;
  assign bus.sof_err  = sof_err_q;
  assign bus.win_data = win_data_q;

endmodule

// File: tb/tb_conv3x3_win_gen.sv
// Bench for conv3x3_win_gen: 4x4 two-channel instance checked cycle by cycle against an
// image-array reference, plus a 5x5 single-channel instance for window placement.
// Expected values follow CONV_WIN_STRIDE2_EN when it is defined.
module tb_conv3x3_win_gen;

  localparam int AW = 4, AH = 4, ACH = 2;
  localparam int BW = 5, BH = 5;

  logic clk;
  logic rst_b;

  conv3x3_win_gen_if #(.DATAW(8), .IFM_CH(ACH), .K(3)) bus_a ();
  conv3x3_win_gen_if #(.DATAW(8), .IFM_CH(1),   .K(3)) bus_b ();

  conv3x3_win_gen #(.DATAW(8), .IFM_CH(ACH), .K(3), .IMG_W(AW), .IMG_H(AH)) dut_a (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus_a)
  );

  conv3x3_win_gen #(.DATAW(8), .IFM_CH(1), .K(3), .IMG_W(BW), .IMG_H(BH)) dut_b (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  // Directed window record: nine channel-0 values listed ky-major (top-left first).
  typedef struct packed {
    logic [0:8][7:0] v;
    logic            last;
  } win_rec_t;

  win_rec_t tbl [4];
  int       tbl_n, tbl_k;
  bit       tbl_on;

  int n_chk, n_fail;
  int n_win, n_last, n_err;

  // Reference state for instance A: the frame as an image, plus raster position.
  logic [15:0]        img [AH][AW];
  int                 m_row, m_col;
  logic [ACH*72-1:0]  e_data;
  logic               e_vld, e_last, e_err;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit win_gate(input int r0, input int c0);
`ifdef CONV_WIN_STRIDE2_EN
    return (r0 % 2 == 0) && (c0 % 2 == 0);
`else
    return (r0 >= 0) && (c0 >= 0);
`endif
  endfunction

  function automatic bit is_last_win(input int r0, input int c0, input int h, input int w);
`ifdef CONV_WIN_STRIDE2_EN
    return (r0 == (h - 3) - (h - 3) % 2) && (c0 == (w - 3) - (w - 3) % 2);
`else
    return (r0 == h - 3) && (c0 == w - 3);
`endif
  endfunction

  function automatic logic [ACH*72-1:0] rec_bus(input win_rec_t r);
    logic [ACH*72-1:0] b;
    b = '0;
    for (int c = 0; c < ACH; c++)
      for (int i = 0; i < 9; i++)
        b[(c*9 + i)*8 +: 8] = r.v[i] + 8'(c * 100);
    return b;
  endfunction

  task automatic model_a_step(input logic vld, input logic sof, input logic [15:0] pix);
    e_vld  = 1'b0;
    e_last = 1'b0;
    e_err  = 1'b0;
    if (vld) begin
      if (sof) begin
        if (m_row != 0 || m_col != 0) e_err = 1'b1;
        m_row = 0;
        m_col = 0;
      end
      img[m_row][m_col] = pix;
      if (m_row >= 2 && m_col >= 2 && win_gate(m_row - 2, m_col - 2)) begin
        e_vld = 1'b1;
        for (int c = 0; c < ACH; c++)
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              e_data[(c*9 + ky*3 + kx)*8 +: 8] = img[m_row-2+ky][m_col-2+kx][c*8 +: 8];
        e_last = is_last_win(m_row - 2, m_col - 2, AH, AW);
      end
      m_col++;
      if (m_col == AW) begin
        m_col = 0;
        m_row++;
        if (m_row == AH) m_row = 0;
      end
    end
  endtask

  task automatic drive_a(input logic vld, input logic sof, input logic [15:0] pix);
    bus_a.in_vld = vld;
    bus_a.in_sof = sof;
    bus_a.in_pix = pix;
    model_a_step(vld, sof, pix);
    @(posedge clk);
    #1;
    check("a_flags", {bus_a.win_vld, bus_a.win_last, bus_a.sof_err}, {e_vld, e_last, e_err});
    check("a_data", bus_a.win_data, e_data);
    if (bus_a.win_vld)  n_win++;
    if (bus_a.win_last) n_last++;
    if (bus_a.sof_err)  n_err++;
    if (tbl_on && bus_a.win_vld) begin
      if (tbl_k < tbl_n) begin
        check("tbl_data", bus_a.win_data, rec_bus(tbl[tbl_k]));
        check("tbl_last", bus_a.win_last, tbl[tbl_k].last);
      end else begin
        check("tbl_extra_window", tbl_k, tbl_n - 1);
      end
      tbl_k++;
    end
  endtask

  task automatic frame_a(input bit gap, input bit sof);
    for (int r = 0; r < AH; r++)
      for (int c = 0; c < AW; c++) begin
        drive_a(1'b1, sof && r == 0 && c == 0, {8'(r*AW + c + 100), 8'(r*AW + c)});
        if (gap) drive_a(1'b0, 1'b0, 16'($urandom));
      end
  endtask

  task automatic reset_all();
    rst_b = 1'b0;
    bus_a.in_vld = 1'b0; bus_a.in_sof = 1'b0; bus_a.in_pix = '0;
    bus_b.in_vld = 1'b0; bus_b.in_sof = 1'b0; bus_b.in_pix = '0;
    repeat (2) @(posedge clk);
    #1;
    m_row = 0; m_col = 0;
    e_vld = 1'b0; e_last = 1'b0; e_err = 1'b0; e_data = '0;
    check("rst_a_flags", {bus_a.win_vld, bus_a.win_last, bus_a.sof_err}, 3'b000);
    check("rst_a_data", bus_a.win_data, '0);
    check("rst_b_flags", {bus_b.win_vld, bus_b.win_last, bus_b.sof_err}, 3'b000);
    check("rst_b_data", bus_b.win_data, '0);
    rst_b = 1'b1;
  endtask

  task automatic phase_start(input bit use_tbl);
    n_win = 0; n_last = 0; n_err = 0;
    tbl_k = 0;
    tbl_on = use_tbl;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected test end");
    $fatal(1);
  end

  initial begin
    int exp_q[$];
    int nb, lastb;

    clk = 1'b0;
    n_chk = 0; n_fail = 0;
    tbl_on = 1'b0;

`ifdef CONV_WIN_STRIDE2_EN
    tbl_n  = 1;
    tbl[0] = {{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10}, 1'b1};
`else
    tbl_n  = 4;
    tbl[0] = {{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10}, 1'b0};
    tbl[1] = {{8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11}, 1'b0};
    tbl[2] = {{8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14}, 1'b0};
    tbl[3] = {{8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15}, 1'b1};
`endif

    reset_all();

    // Continuous 4x4 frame; second channel is first channel + 100.
    phase_start(1'b1);
    frame_a(1'b0, 1'b1);
    drive_a(1'b0, 1'b0, '0);
    check("cont_windows", tbl_k, tbl_n);
    check("cont_last", n_last, 1);

    // Same frame with in_vld toggling every cycle.
    phase_start(1'b1);
    frame_a(1'b1, 1'b1);
    check("gap_windows", tbl_k, tbl_n);

    // Two frames back to back, second without in_sof.
    phase_start(1'b0);
    frame_a(1'b0, 1'b1);
    frame_a(1'b0, 1'b0);
    drive_a(1'b0, 1'b0, '0);
    check("b2b_windows", n_win, 2 * tbl_n);
    check("b2b_last", n_last, 2);
    check("b2b_sof_err", n_err, 0);

    // Partial frame up to (1,1), then in_sof lands where (1,2) was expected.
    phase_start(1'b1);
    for (int i = 0; i < 6; i++)
      drive_a(1'b1, i == 0, {8'(i + 100), 8'(i)});
    frame_a(1'b0, 1'b1);
    drive_a(1'b0, 1'b0, '0);
    check("sof_mid_err", n_err, 1);
    check("sof_mid_windows", tbl_k, tbl_n);

    // Reset after one window of a partial frame, then a frame without in_sof.
    phase_start(1'b0);
    for (int i = 0; i < 11; i++)
      drive_a(1'b1, i == 0, 16'($urandom));
    reset_all();
    phase_start(1'b1);
    frame_a(1'b0, 1'b0);
    drive_a(1'b0, 1'b0, '0);
    check("post_rst_windows", tbl_k, tbl_n);

    // Randomised traffic with occasional in_sof.
    phase_start(1'b0);
    for (int i = 0; i < 800; i++) begin
      logic v;
      v = ($urandom % 4) != 0;
      drive_a(v, v && ($urandom % 50 == 0), 16'($urandom));
    end

    // 5x5 single-channel frame: window placement and count.
    for (int r0 = 0; r0 <= BH - 3; r0++)
      for (int c0 = 0; c0 <= BW - 3; c0++)
        if (win_gate(r0, c0)) exp_q.push_back(r0 * BW + c0);
    nb = exp_q.size();
    lastb = 0;
    for (int p = 0; p <= BW * BH; p++) begin
      bus_b.in_vld = (p < BW * BH);
      bus_b.in_sof = (p == 0);
      bus_b.in_pix = 8'(p);
      @(posedge clk);
      #1;
      if (bus_b.win_vld) begin
        if (exp_q.size() == 0) begin
          check("b_extra_window", bus_b.win_vld, 1'b0);
        end else begin
          logic [71:0] eb;
          int tl;
          tl = exp_q.pop_front();
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              eb[(ky*3 + kx)*8 +: 8] = 8'(tl + ky * BW + kx);
          check("b_data", bus_b.win_data, eb);
          check("b_last", bus_b.win_last, exp_q.size() == 0);
        end
      end
      if (bus_b.win_last) lastb++;
    end
    bus_b.in_vld = 1'b0;
    bus_b.in_sof = 1'b0;
    check("b_windows_missing", exp_q.size(), 0);
    check("b_window_count", nb - exp_q.size(), nb);
    check("b_last_count", lastb, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
